// File: rtl/write_axi_pkg.sv
// Shared types and AXI encodings for the sample write-burst controller.
//   state_e        : controller FSM states
//   AXI_RESP_OKAY  : bresp value for a successful write
//   AXI_SIZE_16    : awsize for 16-bit beats
//   AXI_BURST_INCR : incrementing burst type
package write_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_16    = 3'b001;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/write_axi_burst_ctrl_if.sv
// AXI4 write channels (AW, W, B) used by the sample write-burst controller.
//   master : burst controller side (drives aw*/w*/bready)
//   slave  : memory/interconnect side (drives awready/wready/bvalid/bresp)
interface write_axi_burst_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [15:0]       wdata;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wlast,
    output bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wlast,
    input  bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a fall-through head (head shows the oldest
// entry whenever the FIFO is not empty).
//   clk, reset_n    : clock and synchronous active-low reset
//   push, push_data : write request and sample
//   pop             : remove head entry (ignored when empty)
//   head            : oldest stored sample
//   count           : number of stored samples (0..DEPTH)
//   full, empty     : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module sample_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Sample storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/write_axi_burst_ctrl.sv
// Buffers resynchronised samples and writes them as fixed-length AXI4 INCR
// bursts of 16-bit beats into a circular capture window at base_addr.
//   clock_50, reset_n          : clock and synchronous active-low reset
//   base_addr                  : window base, captured when a burst starts
//   enable                     : permits new bursts (FIFO fills regardless)
//   sample_valid, sample_data  : incoming sample stream
//   axi                        : AXI write master (AW, W, B channels)
//   overflow                   : sticky, a sample was dropped on a full FIFO
//   wr_err                     : sticky, a non-OKAY write response was seen
//   busy                       : a burst is in progress
module write_axi_burst_ctrl
  import write_axi_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 32,
  parameter int WIN_BYTES = 4096
) (
  input  logic                 clock_50,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  write_axi_burst_ctrl_if.master axi,
  output logic                 overflow,
  output logic                 wr_err,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN * 2);
  localparam logic [ADDR_W-1:0] WIN       = ADDR_W'(WIN_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e            state_r;
  logic              awvalid_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic              wvalid_r;
  logic              wlast_r;
  logic              bready_r;
  logic [BEAT_W-1:0] beat_r;
  logic [ADDR_W-1:0] offset_r;
  logic [ADDR_W-1:0] offset_step_s;
  logic [ADDR_W-1:0] offset_next_s;
  logic              busy_r;
  logic              wr_err_r;
  logic              overflow_r;

  logic [DATA_W-1:0] head_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              drop_s;
  logic              burst_ready_s;

  // In DATA the FIFO always holds a full burst, so empty_s only guards misuse.
  assign pop_s         = wvalid_r && axi.wready && !empty_s;
  assign drop_s        = sample_valid && full_s && !pop_s;
  assign burst_ready_s = (count_s >= CNT_W'(BURST_LEN));

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clock_50),
    .reset_n   (reset_n),
    .push      (sample_valid),
    .push_data (sample_data),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next window offset; bursts never straddle the window end, so it lands exactly on WIN.
  always_comb begin
    offset_step_s = offset_r + STEP;
    if (offset_step_s >= WIN) begin
      offset_next_s = {ADDR_W{1'b0}};
    end else begin
      offset_next_s = offset_step_s;
    end
  end

  // Burst sequencer: address phase, data beats, response, all outputs registered.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      awvalid_r <= 1'b0;
      awaddr_r  <= {ADDR_W{1'b0}};
      wvalid_r  <= 1'b0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      beat_r    <= {BEAT_W{1'b0}};
      offset_r  <= {ADDR_W{1'b0}};
      busy_r    <= 1'b0;
      wr_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && burst_ready_s) begin
            state_r   <= ADDR;
            awvalid_r <= 1'b1;
            awaddr_r  <= base_addr + offset_r;
            busy_r    <= 1'b1;
          end
        end
        ADDR: begin
          if (axi.awready) begin
            state_r   <= DATA;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            beat_r    <= {BEAT_W{1'b0}};
            wlast_r   <= (LAST_BEAT == {BEAT_W{1'b0}});
          end
        end
        DATA: begin
          if (axi.wready) begin
            if (beat_r == LAST_BEAT) begin
              state_r  <= RESP;
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
            end else begin
              beat_r  <= beat_r + 1'b1;
              wlast_r <= (BEAT_W'(beat_r + 1'b1) == LAST_BEAT);
            end
          end
        end
        RESP: begin
          if (axi.bvalid) begin
            state_r  <= IDLE;
            bready_r <= 1'b0;
            busy_r   <= 1'b0;
            // Failed bursts are not retried; the window still moves on.
            offset_r <= offset_next_s;
            if (axi.bresp != AXI_RESP_OKAY) begin
              wr_err_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          wlast_r   <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for samples dropped on a full FIFO.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign axi.awvalid = awvalid_r;
  assign axi.awaddr  = awaddr_r;
  assign axi.awlen   = 8'(BURST_LEN - 1);
  assign axi.awsize  = AXI_SIZE_16;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = wvalid_r;
  assign axi.wdata   = 16'(head_s);
  assign axi.wlast   = wlast_r;
  assign axi.bready  = bready_r;
  assign overflow    = overflow_r;
  assign wr_err      = wr_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_write_axi_burst_ctrl.sv
// Bench for write_axi_burst_ctrl: directed scenarios plus a long randomized
// run, all checked by a sample-queue / burst-address reference model.
module tb_write_axi_burst_ctrl;

  localparam int DATA_W    = 14;
  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 8;
  localparam int ADDR_W    = 32;
  localparam int WIN_BYTES = 4096;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic              clock_50 = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] base_addr;
  logic              enable;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              overflow;
  logic              wr_err;
  logic              busy;

  always #5 clock_50 = ~clock_50;

  write_axi_burst_ctrl_if #(.ADDR_W(ADDR_W)) axi_bus ();

  write_axi_burst_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .ADDR_W    (ADDR_W),
    .WIN_BYTES (WIN_BYTES)
  ) dut (
    .clock_50     (clock_50),
    .reset_n      (reset_n),
    .base_addr    (base_addr),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .axi          (axi_bus),
    .overflow     (overflow),
    .wr_err       (wr_err),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [31:0]       aw_log[$];
  bit                exp_ovf, exp_err, in_data, wait_b;
  int                beat, aw_cnt, b_cnt, w_cnt;
  bit                prev_aw_stall, prev_w_stall, prev_wlast;
  logic [31:0]       prev_awaddr;
  logic [15:0]       prev_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    return BASE + 32'((k * BURST_LEN * 2) % WIN_BYTES);
  endfunction

  task automatic clear_model();
    q.delete();
    aw_log.delete();
    exp_ovf = 1'b0; exp_err = 1'b0; in_data = 1'b0; wait_b = 1'b0;
    beat = 0; aw_cnt = 0; b_cnt = 0; w_cnt = 0;
    prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
  endtask

  // Called at the falling edge: checks current outputs, then applies the
  // transfers that the coming rising edge will complete.
  task automatic monitor();
    bit aw_hs, w_hs, b_hs;
    int sz;
    logic [DATA_W-1:0] d;
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("wr_err", 32'(wr_err), 32'(exp_err));
    if (prev_aw_stall) begin
      check_eq("awvalid_hold", 32'(axi_bus.awvalid), 32'd1);
      check_eq("awaddr_hold", axi_bus.awaddr, prev_awaddr);
    end
    if (prev_w_stall) begin
      check_eq("wvalid_hold", 32'(axi_bus.wvalid), 32'd1);
      check_eq("wdata_hold", 32'(axi_bus.wdata), 32'(prev_wdata));
      check_eq("wlast_hold", 32'(axi_bus.wlast), 32'(prev_wlast));
    end
    if (axi_bus.wvalid) check_eq("w_after_aw", 32'(in_data), 32'd1);
    if (!reset_n) begin
      clear_model();
      return;
    end
    aw_hs = axi_bus.awvalid && axi_bus.awready;
    w_hs  = axi_bus.wvalid && axi_bus.wready;
    b_hs  = axi_bus.bvalid && axi_bus.bready;
    sz    = q.size();
    if (aw_hs) begin
      check_eq("aw_overlap", 32'({in_data, wait_b}), 32'd0);
      check_eq("awaddr", axi_bus.awaddr, exp_addr(aw_cnt));
      check_eq("awlen", 32'(axi_bus.awlen), 32'(BURST_LEN - 1));
      check_eq("awsize", 32'(axi_bus.awsize), 32'd1);
      check_eq("awburst", 32'(axi_bus.awburst), 32'd1);
      aw_log.push_back(axi_bus.awaddr);
      aw_cnt++;
      in_data = 1'b1;
      beat = 0;
    end
    if (w_hs) begin
      check_eq("w_fifo_nonempty", 32'(sz > 0), 32'd1);
      if (sz > 0) begin
        d = q.pop_front();
        check_eq("wdata", 32'(axi_bus.wdata), 32'(d));
      end
      check_eq("wlast", 32'(axi_bus.wlast), 32'(beat == BURST_LEN - 1));
      beat++;
      w_cnt++;
      if (beat == BURST_LEN) begin
        in_data = 1'b0;
        wait_b  = 1'b1;
      end
    end
    if (b_hs) begin
      check_eq("b_expected", 32'(wait_b), 32'd1);
      wait_b = 1'b0;
      b_cnt++;
      if (axi_bus.bresp != 2'b00) exp_err = 1'b1;
    end
    if (sample_valid) begin
      if (sz < DEPTH || w_hs) q.push_back(sample_data);
      else exp_ovf = 1'b1;
    end
    prev_aw_stall = axi_bus.awvalid && !axi_bus.awready;
    prev_awaddr   = axi_bus.awaddr;
    prev_w_stall  = axi_bus.wvalid && !axi_bus.wready;
    prev_wdata    = axi_bus.wdata;
    prev_wlast    = axi_bus.wlast;
  endtask

  task automatic cycle();
    monitor();
    @(posedge clock_50);
    @(negedge clock_50);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic set_idle();
    enable          = 1'b1;
    sample_valid    = 1'b0;
    sample_data     = 14'd0;
    axi_bus.awready = 1'b1;
    axi_bus.wready  = 1'b1;
    axi_bus.bvalid  = 1'b1;
    axi_bus.bresp   = 2'b00;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    set_idle();
    cycle();
    reset_n = 1'b1;
    check_eq({tag, "_awvalid"}, 32'(axi_bus.awvalid), 32'd0);
    check_eq({tag, "_wvalid"}, 32'(axi_bus.wvalid), 32'd0);
    check_eq({tag, "_bready"}, 32'(axi_bus.bready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_wr_err"}, 32'(wr_err), 32'd0);
  endtask

  initial begin
    int aw_seen;
    reset_n   = 1'b0;
    base_addr = BASE;
    set_idle();
    clear_model();
    repeat (2) @(posedge clock_50);
    @(negedge clock_50);

    // Basic burst: 8 samples, always-ready slave
    do_reset("rst0");
    for (int i = 1; i <= 8; i++) push(14'(i));
    run(20);
    check_eq("t1_beats", 32'(w_cnt), 32'd8);
    check_eq("t1_bursts", 32'(b_cnt), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_awaddr", (aw_log.size() > 0) ? aw_log[0] : 32'hFFFF_FFFF, BASE);

    // Threshold: 7 samples start nothing, the 8th starts a burst
    do_reset("rst1");
    for (int i = 0; i < 7; i++) push(14'(32 + i));
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_eq("t2_no_aw", 32'(axi_bus.awvalid), 32'd0);
    end
    push(14'd39);
    cycle();
    check_eq("t2_aw_start", 32'(axi_bus.awvalid), 32'd1);
    run(20);
    check_eq("t2_beats", 32'(w_cnt), 32'd8);

    // Stalls: awready low for 5 cycles, wready toggling
    do_reset("rst2");
    axi_bus.awready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      axi_bus.wready = i[0];
      push(14'(14'h0A0 + i));
    end
    aw_seen = 0;
    for (int i = 0; i < 80 && b_cnt < 1; i++) begin
      axi_bus.awready = (aw_seen >= 5);
      axi_bus.wready  = i[0];
      cycle();
      if (axi_bus.awvalid) aw_seen++;
    end
    check_eq("t3_done", 32'(b_cnt), 32'd1);
    check_eq("t3_beats", 32'(w_cnt), 32'd8);
    check_eq("t3_aw_stalled", 32'(aw_seen >= 5), 32'd1);

    // Overflow: wready held low, 17th sample is dropped
    do_reset("rst3");
    axi_bus.wready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check_eq("t4_no_ovf_yet", 32'(overflow), 32'd0);
      push(14'(14'h100 + i));
    end
    check_eq("t4_ovf", 32'(overflow), 32'd1);
    axi_bus.wready = 1'b1;
    run(40);
    check_eq("t4_drained", 32'(q.size()), 32'd0);
    check_eq("t4_beats", 32'(w_cnt), 32'd16);

    // Randomized traffic across the full window and its wrap
    do_reset("rst4");
    for (int i = 0; i < 20000 && aw_cnt < 257; i++) begin
      sample_valid    = ($urandom_range(0, 1) == 1);
      sample_data     = 14'($urandom);
      axi_bus.awready = ($urandom_range(0, 3) != 0);
      axi_bus.wready  = ($urandom_range(0, 3) != 0);
      axi_bus.bvalid  = ($urandom_range(0, 3) != 0);
      axi_bus.bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      cycle();
    end
    check_eq("t5_reached", 32'(aw_cnt), 32'd257);
    check_eq("t5_last_in_win", (aw_log.size() > 255) ? aw_log[255] : 32'hFFFF_FFFF, 32'h0000_1FF0);
    check_eq("t5_wrap", (aw_log.size() > 256) ? aw_log[256] : 32'hFFFF_FFFF, BASE);
    set_idle();
    run(40);
    check_eq("t5_all_resp", 32'(b_cnt), 32'(aw_cnt));

    // Error response on burst 2, then reset in the middle of a data phase
    do_reset("rst5");
    for (int i = 0; i < 64 && b_cnt < 3; i++) begin
      axi_bus.bresp = (b_cnt == 1) ? 2'b10 : 2'b00;
      sample_valid  = (i < 24);
      sample_data   = 14'(14'h200 + i);
      cycle();
    end
    sample_valid  = 1'b0;
    axi_bus.bresp = 2'b00;
    run(2);
    check_eq("t6_bursts", 32'(b_cnt), 32'd3);
    check_eq("t6_wr_err", 32'(wr_err), 32'd1);
    check_eq("t6_addr3", (aw_log.size() > 2) ? aw_log[2] : 32'hFFFF_FFFF, 32'h0000_1020);
    axi_bus.wready = 1'b0;
    for (int i = 0; i < 17; i++) push(14'(14'h300 + i));
    check_eq("t6_in_data", 32'(axi_bus.wvalid), 32'd1);
    check_eq("t6_ovf_set", 32'(overflow), 32'd1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_eq("t6_rst_awvalid", 32'(axi_bus.awvalid), 32'd0);
    check_eq("t6_rst_wvalid", 32'(axi_bus.wvalid), 32'd0);
    check_eq("t6_rst_bready", 32'(axi_bus.bready), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_overflow", 32'(overflow), 32'd0);
    check_eq("t6_rst_wr_err", 32'(wr_err), 32'd0);
    axi_bus.wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t6_fifo_empty", 32'(axi_bus.awvalid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
